// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between p_NUM_REQ requesters, one word per grant.
// Define UART_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module uart_tx_arbiter #(
  parameter int p_NUM_REQ  = 4,
  parameter int p_WORD_LEN = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [p_NUM_REQ-1:0]            i_req,
  input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_data,
  output logic [p_NUM_REQ-1:0]            o_gnt,
  output logic [p_NUM_REQ-1:0]            o_done,
  output logic                            o_busy,
  output logic                            o_tx_send,
  output logic [p_WORD_LEN-1:0]           o_tx_data,
  input  logic                            i_tx_done,
  input  logic                            i_tx_active
);
  localparam int W = $clog2(p_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    DRAIN
  } state_t;

  state_t state, state_n;
  logic [W-1:0] r_owner, owner_n;
  logic [W-1:0] r_ptr, win;
  logic [W:0] sum;
  logic r_done_q, found, issue, send_n;
  logic [p_NUM_REQ-1:0] gnt_n, done_n;
  logic [2*p_NUM_REQ-1:0] req_rot;
  logic [p_WORD_LEN-1:0] data_n;

`ifdef UART_ARB_RR_EN
  logic [W-1:0] ptr_n;

  always_comb begin
    ptr_n = r_ptr;
    if (state == SEND) begin
      if (int'(r_owner) == p_NUM_REQ-1) ptr_n = '0;
      else ptr_n = r_owner + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ptr <= '0;
    else r_ptr <= ptr_n;
  end
`else
  assign r_ptr = '0;
`endif

  // Rotate so bit 0 is the pointer position; first hit wins.
  assign req_rot = {i_req, i_req} >> r_ptr;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < p_NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, r_ptr} + (W+1)'(i);
        if (sum >= (W+1)'(p_NUM_REQ))
          win = W'(sum - (W+1)'(p_NUM_REQ));
        else
          win = W'(sum);
      end
    end
  end

  assign issue = (|i_req) && !i_tx_active && !i_tx_done;

  always_comb begin
    state_n = state;
    owner_n = r_owner;
    gnt_n   = '0;
    done_n  = '0;
    send_n  = 1'b0;
    data_n  = o_tx_data;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_n = SEND;
          owner_n = win;
          send_n  = 1'b1;
          gnt_n   = p_NUM_REQ'(1) << win;
          for (int k = 0; k < p_NUM_REQ; k++)
            if (win == W'(k))
              data_n = i_data[k*p_WORD_LEN +: p_WORD_LEN];
        end
      end
      SEND: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done && !r_done_q) begin
          done_n  = p_NUM_REQ'(1) << r_owner;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_tx_done && !i_tx_active) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      r_owner   <= '0;
      r_done_q  <= 1'b0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_tx_send <= 1'b0;
      o_tx_data <= '0;
    end else begin
      state     <= state_n;
      r_owner   <= owner_n;
      r_done_q  <= i_tx_done;
      o_gnt     <= gnt_n;
      o_done    <= done_n;
      o_tx_send <= send_n;
      o_tx_data <= data_n;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level model of the arbiter in front of a
// behavioural uart_tx (10 bits x div 4, 2-cycle done); directed plus random requests.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int WL = 8;
  localparam int FRAME = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*WL-1:0] data = '0;
  logic [N-1:0] o_gnt, o_done;
  logic o_busy, o_tx_send;
  logic [WL-1:0] o_tx_data;
  logic tx_done = 1'b0;
  logic tx_active = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.p_NUM_REQ(N), .p_WORD_LEN(WL)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_data(data),
    .o_gnt(o_gnt),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_tx_send(o_tx_send),
    .o_tx_data(o_tx_data),
    .i_tx_done(tx_done),
    .i_tx_active(tx_active)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transmitter stand-in: no reset, like the real one.
  int tx_phase = 0;
  int tx_cnt = 0;
  int tx_overlap = 0;
  int line_q[$];

  always @(posedge clk) begin
    case (tx_phase)
      0: if (o_tx_send) begin
        tx_phase  <= 1;
        tx_active <= 1'b1;
        tx_cnt    <= FRAME - 1;
        line_q.push_back(int'(o_tx_data));
      end
      1: begin
        if (o_tx_send) tx_overlap <= tx_overlap + 1;
        if (tx_cnt == 0) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          tx_cnt    <= 1;
          tx_phase  <= 2;
        end else tx_cnt <= tx_cnt - 1;
      end
      default: begin
        if (o_tx_send) tx_overlap <= tx_overlap + 1;
        if (tx_cnt == 0) begin
          tx_done  <= 1'b0;
          tx_phase <= 0;
        end else tx_cnt <= tx_cnt - 1;
      end
    endcase
  end

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference: at each edge, decide what the arbiter must show from the
  // inputs it saw at that edge. Compared on the falling edge.
  int gq[$];
  int dq[$];
  bit in_frame = 0;
  bit saw_done = 0;
  int m_ptr = 0;
  int owner = 0;
  logic [WL-1:0] m_data = '0;
  logic [N-1:0] p_req = '0;
  logic [N*WL-1:0] p_data = '0;
  logic p_done = 1'b0, pp_done = 1'b0, p_act = 1'b0, p_rst = 1'b0;

  initial begin
    logic [N-1:0] e_gnt, e_done;
    int w;
    forever begin
      @(negedge clk);
      e_gnt = '0;
      e_done = '0;
      if (!rst_n || !p_rst) begin
        in_frame = 0;
        saw_done = 0;
        m_ptr = 0;
        m_data = '0;
      end else if (!in_frame) begin
        if ((|p_req) && !p_act && !p_done) begin
          w = pick(p_req, m_ptr);
          e_gnt[w] = 1'b1;
          m_data = p_data[w*WL +: WL];
          owner = w;
          in_frame = 1;
          saw_done = 0;
`ifdef UART_ARB_RR_EN
          m_ptr = (w + 1) % N;
`endif
        end
      end else if (!saw_done) begin
        if (p_done && !pp_done) begin
          e_done[owner] = 1'b1;
          saw_done = 1;
        end
      end else if (!p_done && !p_act) begin
        in_frame = 0;
      end
      chk("gnt", 64'(o_gnt), 64'(e_gnt));
      chk("send", 64'(o_tx_send), 64'(|e_gnt));
      chk("data", 64'(o_tx_data), 64'(m_data));
      chk("done", 64'(o_done), 64'(e_done));
      chk("busy", 64'(o_busy), 64'(in_frame));
      for (int k = 0; k < N; k++) begin
        if (o_gnt[k]) gq.push_back(k);
        if (o_done[k]) dq.push_back(k);
      end
      p_req = req;
      p_data = data;
      pp_done = p_done;
      p_done = tx_done;
      p_act = tx_active;
      p_rst = rst_n;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_async",
           64'({o_gnt, o_done, o_busy, o_tx_send, o_tx_data}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (o_gnt[k]) return;
    end
    chk("gnt_timeout", 64'(o_gnt), 64'(1) << k);
  endtask

  task automatic wait_ngnt(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (gq.size() >= n) return;
    end
    chk("ngnt_timeout", 64'(gq.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (!o_busy && !tx_active && !tx_done && tx_phase == 0) return;
    end
    chk("idle_timeout", 64'({o_busy, tx_active, tx_done}), 64'(0));
  endtask

  initial begin
    int gb, db, lb;
    int exp2[6];
    int exp5[3];
`ifdef UART_ARB_RR_EN
    exp2 = '{0, 1, 2, 3, 0, 1};
    exp5 = '{3, 0, 3};
`else
    exp2 = '{0, 0, 0, 0, 0, 1};
    exp5 = '{3, 0, 0};
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state",
        64'({o_gnt, o_done, o_busy, o_tx_send, o_tx_data}), 64'(0));

    // single request
    do_reset();
    gb = gq.size(); db = dq.size(); lb = line_q.size();
    data[2*WL +: WL] = 8'hA5;
    req = 4'b0100;
    wait_gnt(2, 20);
    chk("t1_gnt", 64'(o_gnt), 64'(4'b0100));
    chk("t1_txdata", 64'(o_tx_data), 64'(8'hA5));
    req = '0;
    wait_idle(200);
    chk("t1_ngnt", 64'(gq.size() - gb), 64'(1));
    chk("t1_ndone", 64'(dq.size() - db), 64'(1));
    chk("t1_done_id", 64'(q_at(dq, db)), 64'(2));
    chk("t1_line", 64'(q_at(line_q, lb)), 64'(8'hA5));

    // all four requesting
    do_reset();
    gb = gq.size(); lb = line_q.size();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    wait_ngnt(gb + 5, 400);
    req[0] = 1'b0;
    wait_ngnt(gb + 6, 200);
    req = '0;
    wait_idle(200);
    for (int i = 0; i < 6; i++) begin
      chk("t2_order", 64'(q_at(gq, gb + i)), 64'(exp2[i]));
      chk("t2_line", 64'(q_at(line_q, lb + i)), 64'(8'h10 + exp2[i]));
    end

    // request arrives while another frame is in flight
    do_reset();
    gb = gq.size(); db = dq.size();
    data[1*WL +: WL] = 8'h21;
    req = 4'b0010;
    wait_gnt(1, 20);
    req = '0;
    repeat (12) @(posedge clk);
    #1;
    data[3*WL +: WL] = 8'h3C;
    req = 4'b1000;
    wait_gnt(3, 200);
    chk("t3_gnt", 64'(o_gnt), 64'(4'b1000));
    chk("t3_prev_done", 64'(dq.size() - db), 64'(1));
    chk("t3_txdata", 64'(o_tx_data), 64'(8'h3C));
    req = '0;
    wait_idle(200);
    chk("t3_ndone", 64'(dq.size() - db), 64'(2));
    chk("t3_done_id", 64'(q_at(dq, db + 1)), 64'(3));

    // reset in the middle of a frame
    do_reset();
    data[0 +: WL] = 8'h5A;
    req = 4'b0001;
    wait_gnt(0, 20);
    req = '0;
    repeat (15) @(posedge clk);
    do_reset();
    db = dq.size();
    chk("t4_tx_mid", 64'(tx_active), 64'(1));
    req = 4'b0001;
    wait_gnt(0, 200);
    chk("t4_tx_idle", 64'({tx_active, tx_done}), 64'(0));
    chk("t4_no_done", 64'(dq.size() - db), 64'(0));
    req = '0;
    wait_idle(200);

    // pointer wrap
    do_reset();
    gb = gq.size();
    data[3*WL +: WL] = 8'h33;
    data[0 +: WL] = 8'h44;
    req = 4'b1000;
    wait_gnt(3, 20);
    req = 4'b1001;
    wait_ngnt(gb + 3, 300);
    req = '0;
    wait_idle(200);
    for (int i = 0; i < 3; i++)
      chk("t5_order", 64'(q_at(gq, gb + i)), 64'(exp5[i]));

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (req[k] && o_gnt[k]) begin
          if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(9, 0) == 0) begin
          data[k*WL +: WL] = WL'($urandom);
          req[k] = 1'b1;
        end
      end
      if (c == 2000) do_reset();
    end
    req = '0;
    wait_idle(200);
    chk("tx_overlap", 64'(tx_overlap), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
